input_block_splitter: RTL
=========================

# input_block_splitter

Upstream stage of the compression path: sits between the host receive stream and the compression arbiter and cuts the host stream into fixed-size compression blocks. Every BLOCK_BEATS accepted beats, or at the end of a host transfer, it asserts tlast so the arbiter sees one self-contained block per packet. Data passes through a two-entry skid buffer at full throughput. The block also keeps block and byte statistics and a sticky tkeep-error flag.

## Interface
- DATA_BITS, 512: stream data width; byte count is DATA_BITS/8 = 64.
- BLOCK_BEATS, 64: beats per block (64 × 64 B = 4 KiB); must be ≥ 2.
- aclk  in  1  the only clock.
- aresetn  in  1  reset, synchronous and active-low.
- i_data  AXI4SR.s  DATA_BITS  host receive stream: tdata, tkeep, tlast, tvalid, tready; tid ignored.
- o_data  AXI4S.m  DATA_BITS  blocked stream to the arbiter: tdata, tkeep, tlast, tvalid, tready.
- stat_blocks  out  32  count of blocks fully emitted (output tlast handshakes); wraps.
- stat_bytes  out  48  count of input bytes accepted (popcount of tkeep); wraps.
- err_keep  out  1  sticky flag for an illegal tkeep.

## Operation
- Input beat accepted on i_data.tvalid && i_data.tready; output beat transferred on o_data.tvalid && o_data.tready.
- beat_cnt is log2(BLOCK_BEATS) bits and counts accepted input beats within the current block.
- Output tlast for an accepted beat is (beat_cnt == BLOCK_BEATS-1) || i_data.tlast.
- On an accepted beat with output tlast=1, beat_cnt returns to 0; on any other accepted beat it increments.
- A host transfer of N beats therefore becomes ceil(N/BLOCK_BEATS) blocks. Only the final block can be short.
- tdata and tkeep pass through unmodified.
- Legal tkeep:
  - non-last input beat: all ones;
  - last input beat: contiguous from bit 0 and non-zero.
- Any other tkeep sets err_keep, which stays set until reset. The beat is still forwarded unchanged, and stat_bytes still adds its popcount.
- stat_blocks increments on each output handshake with tlast=1.
- Buffering is a two-entry skid with a main register and a skid register.
  - Beats go out in acceptance order; none are dropped or duplicated.
  - i_data.tready = !skid_valid, driven from a register with no combinational path from o_data.tready.
- Reset (aresetn low on a rising edge) clears, on that edge:
  - both buffer entries, beat_cnt, stat_blocks, stat_bytes, err_keep;
  - o_data.tvalid=0 and i_data.tready=0.
- After reset: i_data.tready=1 on the first cycle with aresetn high.
- Reset mid-block: in-flight beats are discarded, and the next accepted beat starts a new block at beat_cnt=0.

## Timing
- Latency: an input beat accepted at edge k is presented on o_data at cycle k+1 if the buffer was empty.
- Throughput: one beat per cycle sustained while o_data.tready=1.
- Backpressure: when o_data.tready drops with a beat pending, at most one more input beat is accepted into the skid register, then i_data.tready=0 from the next cycle.
- Once the downstream consumes the pending beat, i_data.tready returns to 1 one cycle after the skid register has moved into the main register.
- o_data.tvalid, tdata, tkeep and tlast are held stable while tvalid && !tready.
- Simultaneous input accept and output accept in the same cycle are both honoured with no bubble.
- stat_bytes updates the cycle after input acceptance; stat_blocks updates the cycle after the output tlast handshake.
- All outputs are registered.

## Test plan
- Single transfer, 130 full beats, i_data.tlast on beat 130, o_data.tready=1:
  - 3 output blocks of 64, 64 and 2 beats, tlast on outputs 64, 128, 130;
  - stat_blocks=3, stat_bytes=8320;
  - one beat per cycle with latency 1.
- Transfer of exactly 64 beats: a single tlast on beat 64 with no extra empty block; stat_blocks=1.
- Last beat with tkeep=0x0000_0000_0000_00FF: forwarded unchanged, stat_bytes adds 8, err_keep stays 0.
- Non-last beat with tkeep=0x0F:
  - err_keep=1 and remains 1 over further traffic;
  - data still forwarded.
- Random o_data.tready (50%) and random i_data.tvalid over 10,000 beats:
  - output sequence equals input sequence;
  - stalled outputs stay stable;
  - i_data.tready never depends combinationally on o_data.tready.
- Reset asserted after 20 beats of a block, then 64 new beats sent: first output tlast occurs exactly on new beat 64; stat_blocks=1 and stat_bytes=4096.

Source files
------------

// File: rtl/input_block_splitter.sv
// Cuts the host receive stream into BLOCK_BEATS-beat compression blocks behind a
// two-entry skid buffer, with block/byte statistics and a sticky tkeep-error flag.
module input_block_splitter #(
   parameter int unsigned DATA_BITS   = 512,
   parameter int unsigned BLOCK_BEATS = 64
) (
   input  logic                   aclk,
   input  logic                   aresetn,
   input  logic [DATA_BITS-1:0]   i_data_tdata,
   input  logic [DATA_BITS/8-1:0] i_data_tkeep,
   input  logic                   i_data_tlast,
   input  logic                   i_data_tvalid,
   output logic                   i_data_tready,
   output logic [DATA_BITS-1:0]   o_data_tdata,
   output logic [DATA_BITS/8-1:0] o_data_tkeep,
   output logic                   o_data_tlast,
   output logic                   o_data_tvalid,
   input  logic                   o_data_tready,
   output logic [31:0]            stat_blocks,
   output logic [47:0]            stat_bytes,
   output logic                   err_keep
);

   localparam int unsigned KEEP_BITS = DATA_BITS / 8;
   localparam int unsigned CNT_BITS  = (BLOCK_BEATS > 1) ? $clog2(BLOCK_BEATS) : 1;
   localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(BLOCK_BEATS - 1);

   logic [DATA_BITS-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
   logic [KEEP_BITS-1:0] main_keep_q, main_keep_d, skid_keep_q, skid_keep_d;
   logic                 main_last_q, main_last_d, skid_last_q, skid_last_d;
   logic                 main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
   logic [CNT_BITS-1:0]  beat_cnt_q, beat_cnt_d;
   logic [31:0]          stat_blocks_q, stat_blocks_d;
   logic [47:0]          stat_bytes_q, stat_bytes_d;
   logic                 err_keep_q, err_keep_d;
   logic                 in_ready_q, in_ready_d;

   logic                 in_acc, out_acc, in_last, keep_ok;
   logic [KEEP_BITS-1:0] keep_inc;
   logic [47:0]          keep_pop;

   always_comb begin
      main_data_d   = main_data_q;
      main_keep_d   = main_keep_q;
      main_last_d   = main_last_q;
      main_valid_d  = main_valid_q;
      skid_data_d   = skid_data_q;
      skid_keep_d   = skid_keep_q;
      skid_last_d   = skid_last_q;
      skid_valid_d  = skid_valid_q;
      beat_cnt_d    = beat_cnt_q;
      stat_blocks_d = stat_blocks_q;
      stat_bytes_d  = stat_bytes_q;
      err_keep_d    = err_keep_q;
      keep_pop      = '0;

      in_acc  = i_data_tvalid && in_ready_q;
      out_acc = main_valid_q && o_data_tready;
      in_last = (beat_cnt_q == CNT_LAST) || i_data_tlast;

      // Last beat may be short but must be a non-empty run starting at byte 0.
      keep_inc = i_data_tkeep + KEEP_BITS'(1);
      if (i_data_tlast) begin
         keep_ok = (i_data_tkeep != '0) && ((i_data_tkeep & keep_inc) == '0);
      end else begin
         keep_ok = &i_data_tkeep;
      end

      for (int i = 0; i < int'(KEEP_BITS); i++) begin
         keep_pop = keep_pop + 48'(i_data_tkeep[i]);
      end

      if (skid_valid_q) begin
         // Input is stalled while the skid entry is occupied.
         if (out_acc) begin
            main_data_d  = skid_data_q;
            main_keep_d  = skid_keep_q;
            main_last_d  = skid_last_q;
            skid_valid_d = 1'b0;
         end
      end else if (!main_valid_q || out_acc) begin
         main_valid_d = in_acc;
         if (in_acc) begin
            main_data_d = i_data_tdata;
            main_keep_d = i_data_tkeep;
            main_last_d = in_last;
         end
      end else if (in_acc) begin
         skid_valid_d = 1'b1;
         skid_data_d  = i_data_tdata;
         skid_keep_d  = i_data_tkeep;
         skid_last_d  = in_last;
      end

      if (in_acc) begin
         beat_cnt_d   = in_last ? '0 : beat_cnt_q + CNT_BITS'(1);
         stat_bytes_d = stat_bytes_q + keep_pop;
         if (!keep_ok) begin
            err_keep_d = 1'b1;
         end
      end

      if (out_acc && main_last_q) begin
         stat_blocks_d = stat_blocks_q + 32'd1;
      end

      in_ready_d = !skid_valid_d;
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         main_data_q   <= '0;
         main_keep_q   <= '0;
         main_last_q   <= 1'b0;
         main_valid_q  <= 1'b0;
         skid_data_q   <= '0;
         skid_keep_q   <= '0;
         skid_last_q   <= 1'b0;
         skid_valid_q  <= 1'b0;
         beat_cnt_q    <= '0;
         stat_blocks_q <= '0;
         stat_bytes_q  <= '0;
         err_keep_q    <= 1'b0;
         in_ready_q    <= 1'b0;
      end else begin
         main_data_q   <= main_data_d;
         main_keep_q   <= main_keep_d;
         main_last_q   <= main_last_d;
         main_valid_q  <= main_valid_d;
         skid_data_q   <= skid_data_d;
         skid_keep_q   <= skid_keep_d;
         skid_last_q   <= skid_last_d;
         skid_valid_q  <= skid_valid_d;
         beat_cnt_q    <= beat_cnt_d;
         stat_blocks_q <= stat_blocks_d;
         stat_bytes_q  <= stat_bytes_d;
         err_keep_q    <= err_keep_d;
         in_ready_q    <= in_ready_d;
      end
   end

   assign i_data_tready = in_ready_q;
   assign o_data_tdata  = main_data_q;
   assign o_data_tkeep  = main_keep_q;
   assign o_data_tlast  = main_last_q;
   assign o_data_tvalid = main_valid_q;
   assign stat_blocks   = stat_blocks_q;
   assign stat_bytes    = stat_bytes_q;
   assign err_keep      = err_keep_q;

endmodule
